// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   md_op_e    - operation encoding as presented on the op port
//   md_state_e - sequencer states
//   MD_WIDTH   - default operand width
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIXUP
    } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand capture, abs/negate, one radix-2 multiply or
// restoring-divide step per cycle, and sign-corrected result formation.
//   clk, rst        - clock, async active-high reset
//   load_i          - capture raw operands (start accepted)
//   prep_i          - load working registers with |operands|
//   step_i          - perform one iteration step
//   op_i            - latched operation
//   src_a_i/src_b_i - raw operands
//   res_hi_o/lo_o   - final HI/LO values (valid in FIXUP)
//   div0_o          - divide with zero divisor
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             prep_i,
    input  logic             step_i,
    input  md_op_e           op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             div0_o
);

    logic [WIDTH-1:0]   a_raw_q, b_raw_q, opnd_q, rem_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     sum, r_sh;
    logic               is_signed, is_div, sa, sb, ge;

    assign is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign is_div    = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign sa        = is_signed & a_raw_q[WIDTH-1];
    assign sb        = is_signed & b_raw_q[WIDTH-1];
    assign a_abs     = sa ? -a_raw_q : a_raw_q;
    assign b_abs     = sb ? -b_raw_q : b_raw_q;
    assign div0_o    = is_div && (b_raw_q == '0);

    // Multiply: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand into the upper half when the current LSB is set, then shift.
    assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: acc lower half shifts the dividend out MSB-first and the quotient in.
    assign r_sh = {rem_q, acc_q[WIDTH-1]};
    assign ge   = r_sh >= {1'b0, opnd_q};

    assign prod_fix = (sa ^ sb) ? -acc_q : acc_q;
    assign quo_fix  = (sa ^ sb) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sa ? -rem_q : rem_q;

    always_comb begin
        if (!is_div) begin
            {res_hi_o, res_lo_o} = prod_fix;
        end else if (div0_o) begin
            // Zero divisor reports the untouched dividend in HI.
            res_hi_o = a_raw_q;
            res_lo_o = '1;
        end else begin
            res_hi_o = rem_fix;
            res_lo_o = quo_fix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_raw_q <= '0;
            b_raw_q <= '0;
            opnd_q  <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
        end else if (load_i) begin
            a_raw_q <= src_a_i;
            b_raw_q <= src_b_i;
        end else if (prep_i) begin
            opnd_q <= is_div ? b_abs : a_abs;
            acc_q  <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
            rem_q  <= '0;
        end else if (step_i) begin
            if (is_div) begin
                rem_q <= ge ? WIDTH'(r_sh - {1'b0, opnd_q}) : r_sh[WIDTH-1:0];
                acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ge};
            end else begin
                acc_q <= {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
//   clk, rst      - clock, async active-high reset
//   start, op     - launch request and operation (sampled in IDLE only)
//   src_a, src_b  - rs / rt operands
//   flush         - abort in-flight operation without committing
//   hi_we, lo_we  - MTHI/MTLO strobes with wdata (IDLE only)
//   busy          - registered, high whenever not IDLE
//   done          - one-cycle pulse when HI/LO commit
//   div0          - last committed divide had a zero divisor
//   hi, lo        - HI/LO registers
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;
    logic             busy_q, busy_d, done_q, done_d;
    logic             div0_q, div0_d, div0p_q, div0p_d;
    logic             accept, prep, step, dp_div0;

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .prep_i   (prep),
        .step_i   (step),
        .op_i     (op_q),
        .src_a_i  (src_a),
        .src_b_i  (src_b),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo),
        .div0_o   (dp_div0)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = div0_q;
        div0p_d = div0p_q;
        accept  = 1'b0;
        prep    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                // flush squashes a same-cycle start
                if (start && !flush) begin
                    accept  = 1'b1;
                    op_d    = md_op_e'(op);
                    div0_d  = 1'b0;
                    div0p_d = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (flush) state_d = S_IDLE;
                else begin
                    prep    = 1'b1;
                    cnt_d   = CW'(WIDTH - 1);
                    div0p_d = dp_div0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (flush) state_d = S_IDLE;
                else begin
                    step = 1'b1;
                    if (cnt_q == '0) state_d = S_FIXUP;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            S_FIXUP: begin
                if (flush) state_d = S_IDLE;
                else begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    div0_d  = div0p_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // busy is registered from next state so it never depends on start
        // within the same cycle.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= MD_MULT;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            div0p_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            div0p_q <= div0p_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
